// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   state_e : arbiter FSM encoding (IDLE / ACCESS / CAPTURE)
//   OWN_I   : owner id of the instruction-fetch port
//   OWN_D   : owner id of the load/store port
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational 2-way pick between fetch (I) and load/store (D).
// Build option: MEM_ARB_RR_EN selects round-robin on conflict (the port
// other than ptr wins); without it D always beats I and ptr is ignored.
//   i_req, d_req : qualified requests (already gated to IDLE by the parent)
//   ptr          : owner id of the last-granted port
//   win          : one-hot winner, bit OWN_I / bit OWN_D
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_req,
    input  logic       d_req,
    input  logic       ptr,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            if (ptr == OWN_I) win[OWN_D] = 1'b1;
            else              win[OWN_I] = 1'b1;
`else
            win[OWN_D] = 1'b1;
`endif
        end else begin
            win[OWN_I] = i_req;
            win[OWN_D] = d_req;
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_ptr;
    assign unused_ptr = ptr;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port (1-cycle read latency) between
// instruction fetch (I) and load/store (D).
// Build option: MEM_ARB_RR_EN -> round-robin arbitration with a 1-bit
// last-granted pointer; otherwise fixed priority, D over I.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   i_req/i_addr                   fetch read request
//   i_gnt/i_rvalid/i_rdata         fetch grant pulse, read-data pulse, data
//   d_req/d_we/d_addr/d_wdata      load/store request
//   d_gnt/d_rvalid/d_rdata         load/store grant pulse, load pulse, data
//   busy                           FSM not in IDLE
//   mem_addr/mem_read_en/
//   mem_write_en/mem_write_val     memory drive, active only in ACCESS
//   mem_read_val                   memory read data, valid cycle after read_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int MEM_WIDTH = 32,
    parameter  int MEM_SIZE  = 256,
    localparam int ADDR_W    = $clog2(MEM_SIZE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [31:0]          i_addr,
    output logic                 i_gnt,
    output logic                 i_rvalid,
    output logic [MEM_WIDTH-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [31:0]          d_addr,
    input  logic [31:0]          d_wdata,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [MEM_WIDTH-1:0] d_rdata,
    output logic                 busy,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_read_en,
    output logic                 mem_write_en,
    output logic [MEM_WIDTH-1:0] mem_write_val,
    input  logic [MEM_WIDTH-1:0] mem_read_val
);

    state_e                 state_q, state_d;
    logic                   owner_q, owner_d;
    logic                   we_q, we_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [MEM_WIDTH-1:0]   wdata_q, wdata_d;
    logic                   i_rvalid_q, i_rvalid_d;
    logic                   d_rvalid_q, d_rvalid_d;
    logic [MEM_WIDTH-1:0]   i_rdata_q, i_rdata_d;
    logic [MEM_WIDTH-1:0]   d_rdata_q, d_rdata_d;
    logic                   ptr;
    logic                   can_grant;
    logic                   access;
    logic [1:0]             win;

    // Grants are combinational in IDLE so that gnt and the ACCESS cycle that
    // follows it line up with the read/write latency contract. Reset masks
    // them so every output is 0 while reset is held.
    assign can_grant = (state_q == ST_IDLE) && !reset;
    assign access    = (state_q == ST_ACCESS);

`ifdef MEM_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign ptr   = ptr_q;
    assign ptr_d = (|win) ? win[OWN_D] : ptr_q;
`else
    assign ptr = OWN_I;
`endif

    mem_arb_pick u_pick (
        .i_req (i_req && can_grant),
        .d_req (d_req && can_grant),
        .ptr   (ptr),
        .win   (win)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (|win) begin
                    owner_d = win[OWN_D];
                    we_d    = win[OWN_D] && d_we;
                    addr_d  = win[OWN_D] ? d_addr[ADDR_W-1:0] : i_addr[ADDR_W-1:0];
                    wdata_d = win[OWN_D] ? d_wdata[MEM_WIDTH-1:0] : '0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS:  state_d = we_q ? ST_IDLE : ST_CAPTURE;
            ST_CAPTURE: begin
                state_d = ST_IDLE;
                if (owner_q == OWN_D) begin
                    d_rdata_d  = mem_read_val;
                    d_rvalid_d = 1'b1;
                end else begin
                    i_rdata_d  = mem_read_val;
                    i_rvalid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_I;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= OWN_I;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    assign i_gnt         = win[OWN_I];
    assign d_gnt         = win[OWN_D];
    assign i_rvalid      = i_rvalid_q;
    assign d_rvalid      = d_rvalid_q;
    assign i_rdata       = i_rdata_q;
    assign d_rdata       = d_rdata_q;
    assign busy          = (state_q != ST_IDLE);
    // Memory drive is decoded from the state flop so an asynchronous reset
    // drops the strobes immediately.
    assign mem_addr      = access ? addr_q : '0;
    assign mem_read_en   = access && !we_q;
    assign mem_write_en  = access && we_q;
    assign mem_write_val = (access && we_q) ? wdata_q : '0;

    // Address bits above the memory depth wrap and are intentionally dropped.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{i_addr[31:ADDR_W], d_addr[31:ADDR_W]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, busy;
    logic [31:0] i_rdata, d_rdata, mem_write_val;
    logic [7:0]  mem_addr;
    logic        mem_read_en, mem_write_en;
    logic [31:0] mem_read_val = '0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.MEM_WIDTH(32), .MEM_SIZE(256)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .busy(busy), .mem_addr(mem_addr), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .mem_write_val(mem_write_val),
        .mem_read_val(mem_read_val)
    );

    // Memory array seen by the DUT, plus an independent copy owned by the model.
    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_read_en)  mem_read_val <= tb_mem[mem_addr];
        if (mem_write_en) tb_mem[mem_addr] = mem_write_val;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // Each grant schedules its future effects into a 4-slot window indexed by
    // cycle number: the memory access one cycle later and, for reads, the
    // rvalid/rdata three cycles later. The port is free again at next_free.
    int          cyc, next_free, s, s1, s3;
    logic        last_d;
    bit          sacc [4];
    bit          swr  [4];
    logic [7:0]  saddr[4];
    logic [31:0] swval[4];
    bit          srv  [4];
    bit          sown [4];
    logic [31:0] sdata[4];
    logic [31:0] e_irdata, e_drdata;
    logic        e_busy, e_ig, e_dg, wd, wr;
    logic [7:0]  a;

    always @(negedge clk) begin
        if (reset) begin
            cyc = 0; next_free = 0; last_d = 1'b0;
            e_irdata = '0; e_drdata = '0;
            for (int k = 0; k < 4; k++) begin sacc[k] = 0; srv[k] = 0; end
            chk("reset_ctrl", {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_read_en, mem_write_en}, 0);
            chk("reset_data", {i_rdata, d_rdata, mem_write_val, mem_addr}, 0);
        end else begin
            s      = cyc % 4;
            e_busy = (cyc < next_free);
            e_ig   = 1'b0;
            e_dg   = 1'b0;
            if (!e_busy && (i_req || d_req)) begin
`ifdef MEM_ARB_RR_EN
                wd = d_req && (!i_req || !last_d);
`else
                wd = d_req;
`endif
                e_ig = !wd;
                e_dg = wd;
                a    = wd ? d_addr[7:0] : i_addr[7:0];
                wr   = wd && d_we;
                s1   = (cyc + 1) % 4;
                sacc[s1]  = 1; swr[s1] = wr; saddr[s1] = a;
                swval[s1] = wr ? d_wdata : 32'h0;
                if (wr) begin
                    ref_mem[a] = d_wdata;
                    next_free  = cyc + 2;
                end else begin
                    s3 = (cyc + 3) % 4;
                    srv[s3] = 1; sown[s3] = wd; sdata[s3] = ref_mem[a];
                    next_free = cyc + 3;
                end
                last_d = wd;
            end
            if (srv[s]) begin
                if (sown[s]) e_drdata = sdata[s];
                else         e_irdata = sdata[s];
            end
            chk("gnt", {i_gnt, d_gnt}, {e_ig, e_dg});
            chk("busy", busy, e_busy);
            chk("mem_drive", {mem_read_en, mem_write_en, mem_addr, mem_write_val},
                {sacc[s] && !swr[s], sacc[s] && swr[s], sacc[s] ? saddr[s] : 8'h0,
                 (sacc[s] && swr[s]) ? swval[s] : 32'h0});
            chk("rvalid", {i_rvalid, d_rvalid}, {srv[s] && !sown[s], srv[s] && sown[s]});
            chk("rdata", {i_rdata, d_rdata}, {e_irdata, e_drdata});
            sacc[s] = 0;
            srv[s]  = 0;
            cyc++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    // Returns at the negedge of the cycle in which the selected gnt is high.
    task automatic wait_gnt(input bit is_d);
        int n;
        n = 0;
        @(negedge clk);
        while (!(is_d ? d_gnt : i_gnt) && n < 20) begin @(negedge clk); n++; end
        if (n >= 20) chk("gnt_timeout", 0, 1);
    endtask

    logic [3:0]  seq;
    logic [3:0]  exp_seq;
    logic [31:0] r;
    int          igs, rds, wrs, rvs;
    logic        ig, dg;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tb_mem[i]  = {24'hC0FFEE, i[7:0]};
            ref_mem[i] = {24'hC0FFEE, i[7:0]};
        end
        tb_mem[5]  = 32'h0000_1234;
        ref_mem[5] = 32'h0000_1234;

        // Reset held 3 cycles, then idle with no requests.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) step();

        // I read of a wrapped address.
        i_req = 1; i_addr = 32'h105;
        wait_gnt(0);
        step(); i_req = 0;
        chk("i_rd_addr_wrap", {mem_read_en, mem_addr}, {1'b1, 8'h05});
        step();
        step();
        chk("i_rd_T3", {i_rvalid, i_rdata, d_rvalid}, {1'b1, 32'h1234, 1'b0});

        // D write.
        d_req = 1; d_we = 1; d_addr = 32'h5; d_wdata = 32'hDEADBEEF;
        wait_gnt(1);
        step(); d_req = 0; d_we = 0;
        chk("d_wr_T1", {mem_write_en, mem_read_en, mem_addr, mem_write_val},
            {1'b1, 1'b0, 8'h05, 32'hDEADBEEF});
        step();
        chk("d_wr_T2_idle", busy, 0);

        // Fresh reset so the round-robin pointer starts at "I last".
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();

        // Both requesters held together for four grants.
        i_req = 1; i_addr = 32'h10; d_req = 1; d_we = 0; d_addr = 32'h20;
        seq = '0;
        for (int g = 0; g < 4; g++) begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(i_gnt || d_gnt) && n < 20) begin @(negedge clk); n++; end
            if (n >= 20) chk("arb_timeout", 0, 1);
            seq = {seq[2:0], d_gnt};
        end
        step(); i_req = 0; d_req = 0;
`ifdef MEM_ARB_RR_EN
        exp_seq = 4'b1010;
`else
        exp_seq = 4'b1111;
`endif
        chk("arb_order", seq, exp_seq);
        repeat (4) step();

        // D read aborted by reset during CAPTURE.
        d_req = 1; d_we = 0; d_addr = 32'h22;
        wait_gnt(1);
        step(); d_req = 0;
        step(); reset = 1'b1;
        #1 chk("rst_abort", {busy, mem_read_en, mem_write_en, d_rvalid, d_rdata}, 0);
        step(); reset = 1'b0;
        rvs = 0;
        repeat (4) begin @(negedge clk); if (d_rvalid) rvs++; end
        chk("no_rvalid_after_rst", rvs, 0);
        step();
        d_req = 1; d_addr = 32'h22;
        wait_gnt(1);
        step(); d_req = 0;
        step();
        step();
        chk("d_rd_after_rst", {d_rvalid, d_rdata}, {1'b1, 32'hC0FFEE22});

        // I request withdrawn while D is busy.
        d_req = 1; d_we = 0; d_addr = 32'h40;
        wait_gnt(1);
        step(); d_req = 0; i_req = 1; i_addr = 32'h77;
        igs = 0; rds = 0; wrs = 0;
        @(negedge clk);
        igs += int'(i_gnt); rds += int'(mem_read_en); wrs += int'(mem_write_en);
        step(); i_req = 0;
        repeat (6) begin
            @(negedge clk);
            igs += int'(i_gnt); rds += int'(mem_read_en); wrs += int'(mem_write_en);
        end
        chk("withdraw", {igs[7:0], rds[7:0], wrs[7:0]}, {8'd0, 8'd1, 8'd0});
        step();

        // Randomized traffic with withdrawals, checked every cycle by the model.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            ig = i_gnt;
            dg = d_gnt;
            step();
            if (ig || (i_req && $urandom_range(0, 15) == 0)) i_req = 0;
            else if (!i_req && $urandom_range(0, 2) == 0) begin
                r = $urandom;
                i_req = 1; i_addr = {r[31:8], 4'h0, r[3:0]};
            end
            if (dg || (d_req && $urandom_range(0, 15) == 0)) d_req = 0;
            else if (!d_req && $urandom_range(0, 2) == 0) begin
                r = $urandom;
                d_req = 1; d_we = r[4]; d_addr = {r[31:8], 4'h0, r[3:0]};
                d_wdata = $urandom;
            end
        end
        i_req = 0; d_req = 0;
        repeat (5) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
